// File: rtl/focalpool_pkg.sv
// Shared types for the 2x2 focal max-pool pipeline (row and column stages).
package focalpool_pkg;

  localparam int PIX_W = 4;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t m;
    pix_t n;
  } pair_t;

  typedef enum logic {
    FILL = 1'b0,
    POOL = 1'b1
  } phase_t;

endpackage

// File: rtl/focal_maxpool_col_if.sv
// Ready/valid bundle for the column pooling stage; out_last exists only with FOCALPOOL_LAST_EN.
interface focal_maxpool_col_if;
  import focalpool_pkg::*;

  logic in_valid;
  logic in_ready;
  pix_t in_m;
  pix_t in_n;
  logic out_valid;
  logic out_ready;
  pix_t out_p;
  pix_t out_q;
`ifdef FOCALPOOL_LAST_EN
  logic out_last;
`endif

  // master is the surrounding pipeline (upstream producer plus downstream consumer)
  modport master (
    output in_valid, in_m, in_n, out_ready,
    input  in_ready, out_valid, out_p, out_q
`ifdef FOCALPOOL_LAST_EN
    , input out_last
`endif
  );

  modport slave (
    input  in_valid, in_m, in_n, out_ready,
    output in_ready, out_valid, out_p, out_q
`ifdef FOCALPOOL_LAST_EN
    , output out_last
`endif
  );

endinterface

// File: rtl/focal_max2.sv
// Combinational unsigned maximum of two pixels.
module focal_max2
  import focalpool_pkg::*;
(
  input  pix_t a,
  input  pix_t b,
  output pix_t y
);

  assign y = (a >= b) ? a : b;

endmodule

// File: rtl/focal_maxpool_col.sv
// Vertical 2x2 max-pool stage: buffers one row of pair maxima, then pools the next row against it.
// Optional out_last marker is built when FOCALPOOL_LAST_EN is defined.
module focal_maxpool_col
  import focalpool_pkg::*;
#(
  parameter int ROW_PAIRS = 4
) (
  input logic               clk,
  input logic               rst_n,
  focal_maxpool_col_if.slave bus
);

  localparam int COL_W = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1;

  phase_t           phase, phase_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic             col_end;
  logic             in_fire, out_fire, fill_fire, pool_fire;
  logic             vld_nxt;

  pair_t            line_buf [ROW_PAIRS];
  pair_t            rd_p0;
  pix_t             max_m_p0, max_n_p0;

  logic             vld_p1;
  pix_t             p_p1, q_p1;
`ifdef FOCALPOOL_LAST_EN
  logic             last_p1;
`endif

  // Stage p0: handshake decode, buffer read and lane maxima
  assign col_end   = (col == COL_W'(ROW_PAIRS - 1));
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = vld_p1 && bus.out_ready;
  assign fill_fire = in_fire && (phase == FILL);
  assign pool_fire = in_fire && (phase == POOL);

  // in_ready never looks at in_valid, so upstream may wait on it safely
  assign bus.in_ready = (phase == FILL) || !vld_p1 || bus.out_ready;

  always_comb begin
    rd_p0 = '0;
    for (int i = 0; i < ROW_PAIRS; i++) begin
      if (col == COL_W'(i)) rd_p0 = line_buf[i];
    end
  end

  focal_max2 u_max_m (.a(rd_p0.m), .b(bus.in_m), .y(max_m_p0));
  focal_max2 u_max_n (.a(rd_p0.n), .b(bus.in_n), .y(max_n_p0));

  always_comb begin
    phase_nxt = phase;
    col_nxt   = col;
    vld_nxt   = vld_p1;
    if (in_fire) begin
      if (col_end) begin
        col_nxt   = '0;
        phase_nxt = (phase == FILL) ? POOL : FILL;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
    if (pool_fire)     vld_nxt = 1'b1;
    else if (out_fire) vld_nxt = 1'b0;
  end

  // Buffer is written in FILL before any POOL read, so it needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROW_PAIRS; i++) begin
      if (fill_fire && (col == COL_W'(i))) line_buf[i] <= '{m: bus.in_m, n: bus.in_n};
    end
  end

  // Stage p1: registered pooled pair
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase  <= FILL;
      col    <= '0;
      vld_p1 <= 1'b0;
      p_p1   <= '0;
      q_p1   <= '0;
`ifdef FOCALPOOL_LAST_EN
      last_p1 <= 1'b0;
`endif
    end else begin
      phase  <= phase_nxt;
      col    <= col_nxt;
      vld_p1 <= vld_nxt;
      if (pool_fire) begin
        p_p1 <= max_m_p0;
        q_p1 <= max_n_p0;
`ifdef FOCALPOOL_LAST_EN
        last_p1 <= col_end;
`endif
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_p     = p_p1;
  assign bus.out_q     = q_p1;
`ifdef FOCALPOOL_LAST_EN
  assign bus.out_last  = last_p1;
`endif

endmodule

// File: doc/focal_maxpool_col.md
# focal_maxpool_col

Vertical stage of the 2x2 focal max-pool pipeline. It sits directly downstream of the horizontal row-pooling stage and consumes that stage's per-row pair outputs (M, N: max of pixels A/B and C/D). It buffers one full row of pair maxima. On the following row it takes the element-wise max against the buffer and emits one 2x2-pooled pair per input beat. Ready/valid on both sides lets it stall the upstream row stage when the consumer back-pressures.

## Interface
Parameters:
- ROW_PAIRS, default 4: M/N pairs per image row (row width = 4*ROW_PAIRS pixels); legal range 1..16.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  stage accepts pair this cycle.
- in_m  input  4  left row-max (unsigned).
- in_n  input  4  right row-max (unsigned).
- out_valid  output  1  pooled pair valid.
- out_ready  input  1  downstream accepts pooled pair.
- out_p  output  4  max(buffered M, in_m).
- out_q  output  4  max(buffered N, in_n).
- out_last  output  1  marks final pooled pair of an output row; present only with FOCALPOOL_LAST_EN.

## Operation
- Transfer on the input side occurs when in_valid && in_ready; on the output side when out_valid && out_ready.
- State: row phase bit `phase` (FILL=0, POOL=1), column counter `col` (0..ROW_PAIRS-1), line buffer of ROW_PAIRS entries x 8 bits (M,N), output register.
- FILL: in_ready=1 unconditionally. Each accepted pair is written to buffer[col].
- POOL: in_ready = !out_valid || out_ready. Each accepted pair loads out_p = max(buffer[col].M, in_m) and out_q = max(buffer[col].N, in_n), then sets out_valid.
- Comparison is unsigned 4-bit; on a tie either operand is returned (the values are equal).
- col advances on every accepted pair. At col==ROW_PAIRS-1 it wraps to 0 and phase toggles. ROW_PAIRS=1 toggles phase on every beat.
- out_valid clears on an output transfer with no simultaneous POOL input transfer. A simultaneous output and input transfer keeps out_valid=1 and the register takes the new result (full throughput).
- No outputs are produced in FILL. out_valid can remain high from the last POOL beat while the next row fills.
- Reset (any cycle, including mid-row) clears phase=FILL, col=0, out_valid=0, out_p=0, out_q=0, out_last=0. Buffer contents are not reset; they are always overwritten in FILL before being read.

## Timing
- Latency: 1 cycle from the POOL input transfer to out_valid/out_p/out_q.
- Throughput: 1 pair/cycle in both phases when out_ready=1.
- in_ready is combinational from out_valid, out_ready and phase only; it never depends on in_valid.
- Outputs hold stable while out_valid && !out_ready.
- Buffer read-during-write is not possible: FILL writes, POOL reads, and the two are never in the same row.

## Configuration
- FOCALPOOL_LAST_EN defined: out_last port exists. It is registered alongside out_p/out_q and is 1 when the pair came from col==ROW_PAIRS-1 in POOL.
- FOCALPOOL_LAST_EN undefined: no out_last port and no related logic. All other behaviour is identical.

## Structure
- Shared package focalpool_pkg: PIX_W=4, typedef pix_t (logic [PIX_W-1:0]), typedef pair_t struct {pix_t m; pix_t n;}, typedef enum phase_t {FILL, POOL}. The row stage uses the same package.
- Sub-module focal_max2: combinational unsigned max of two pix_t. Instantiated twice (M lane, N lane).
- The line buffer is a flop array; no macro RAM is used.

## Test plan
- Basic 2x2, ROW_PAIRS=4, out_ready=1. Row0 pairs (1,2),(3,4),(5,6),(7,8), then row1 (8,0),(0,9),(5,5),(2,15). Required outputs: (8,2),(3,9),(5,6),(7,15), each 1 cycle after its input. With FOCALPOOL_LAST_EN, out_last=1 only on (7,15).
- Back-pressure: hold out_ready=0 during row1. Required: first result held stable, in_ready=0 after it. Releasing out_ready drains in order with no loss or duplication.
- Simultaneous transfer: out_ready=1 with continuous in_valid in POOL. Required: out_valid stays 1 for 4 consecutive cycles and a new value every cycle.
- Wrap/multi-row: 4 rows streamed. Required: exactly 2 output rows; the row2 buffer reflects row2 data, not row0.
- Reset mid-row: assert rst_n=0 after 2 POOL beats. Required: out_valid=0, out_p=out_q=0, and the next pair is treated as FILL col 0 (no output).
- ROW_PAIRS=1: input (3,3),(9,1),(0,0),(4,4). Required outputs: (9,3),(4,4).
